// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
// behind a valid/ready handshake, with a radix-2 restoring divider and a
// selectable single-cycle or shift-add multiplier.
module muldiv_iter #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MUL_ITERATIVE = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [XLEN-1:0] bm_q, bm_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            b_zero_in, ovf_in;
  logic [2*XLEN-1:0] prod_fast;
  logic [2*XLEN-1:0] prod_fast_fin;

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi, mul_lo;
  logic [2*XLEN-1:0] mul_fin;

  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;
  logic [XLEN-1:0] div_hi, div_lo;
  logic [XLEN-1:0] quo_fin, rem_fin;

  function automatic logic [XLEN-1:0] pick_half(input logic [2:0] op,
                                                input logic [2*XLEN-1:0] p);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Operand signedness depends on the opcode; unsigned ops and MUL use raw bits.
  always_comb begin
    a_neg_in  = a_i[XLEN-1] & ((op_i == OP_MULH) | (op_i == OP_MULHSU) |
                               (op_i == OP_DIV)  | (op_i == OP_REM));
    b_neg_in  = b_i[XLEN-1] & ((op_i == OP_MULH) | (op_i == OP_DIV) |
                               (op_i == OP_REM));
    a_mag_in  = a_neg_in ? (~a_i + 1'b1) : a_i;
    b_mag_in  = b_neg_in ? (~b_i + 1'b1) : b_i;
    b_zero_in = (b_i == '0);
    ovf_in    = ((op_i == OP_DIV) | (op_i == OP_REM)) &
                (a_i == MIN_INT) & (b_i == {XLEN{1'b1}});
  end

  generate
    if (MUL_ITERATIVE == 0) begin : g_fast_mul
      assign prod_fast = {{XLEN{1'b0}}, a_mag_in} * {{XLEN{1'b0}}, b_mag_in};
    end else begin : g_no_fast_mul
      assign prod_fast = '0;
    end
  endgenerate

  assign prod_fast_fin = (a_neg_in ^ b_neg_in) ? (~prod_fast + 1'b1) : prod_fast;

  // hi/lo double as product accumulator/multiplier and remainder/quotient.
  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? bm_q : {XLEN{1'b0}})};
    mul_hi  = mul_sum[XLEN:1];
    mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    mul_fin = (sa_q ^ sb_q) ? (~{mul_hi, mul_lo} + 1'b1) : {mul_hi, mul_lo};

    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, bm_q});
    div_diff  = div_shift[XLEN-1:0] - bm_q;
    div_hi    = div_ge ? div_diff : div_shift[XLEN-1:0];
    div_lo    = {lo_q[XLEN-2:0], div_ge};
    quo_fin   = (sa_q ^ sb_q) ? (~div_lo + 1'b1) : div_lo;
    rem_fin   = sa_q ? (~div_hi + 1'b1) : div_hi;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bm_d     = bm_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          op_d = op_i;
          sa_d = a_neg_in;
          sb_d = b_neg_in;
          bm_d = b_mag_in;
          hi_d = '0;
          lo_d = a_mag_in;
          if (!op_i[2]) begin
            if (MUL_ITERATIVE != 0) begin
              state_d = S_MUL;
              cnt_d   = CW'(XLEN - 1);
            end else begin
              result_d = pick_half(op_i, prod_fast_fin);
              state_d  = S_DONE;
            end
          end else if (b_zero_in) begin
            result_d = op_i[1] ? a_i : {XLEN{1'b1}};
            state_d  = S_DONE;
          end else if (ovf_in) begin
            result_d = op_i[1] ? {XLEN{1'b0}} : MIN_INT;
            state_d  = S_DONE;
          end else begin
            state_d = S_DIV;
            cnt_d   = CW'(XLEN - 1);
          end
        end
      end
      S_MUL: begin
        hi_d = mul_hi;
        lo_d = mul_lo;
        if (cnt_q == '0) begin
          result_d = pick_half(op_q, mul_fin);
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        hi_d = div_hi;
        lo_d = div_lo;
        if (cnt_q == '0) begin
          result_d = op_q[1] ? rem_fin : quo_fin;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush wins over everything, including a request presented alongside it.
    if (kill_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bm_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bm_q     <= bm_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE) & rst_ni;
  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: single-cycle and iterative multiplier builds side by
// side, table vectors through a scoreboard plus hand-written corner sequences.
module tb_muldiv_iter;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam int NV = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid_i, kill_i;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        rdy0, rdy1, vo0, vo1, bz0, bz1, ri0, ri1;
  logic [31:0] r0, r1;

  muldiv_iter #(.XLEN(32), .MUL_ITERATIVE(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy0), .op_i(op),
    .a_i(a), .b_i(b), .kill_i(kill_i), .valid_o(vo0), .ready_i(ri0),
    .result_o(r0), .busy_o(bz0));

  muldiv_iter #(.XLEN(32), .MUL_ITERATIVE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy1), .op_i(op),
    .a_i(a), .b_i(b), .kill_i(kill_i), .valid_o(vo1), .ready_i(ri1),
    .result_o(r1), .busy_o(bz1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] expd;
    int          due;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expd;
    int          lat0;
    int          lat1;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expd);
    n_vec++;
    if (act !== expd) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expd);
    end
  endtask

  task automatic failNow(input string name);
    n_vec++;
    n_err++;
    $display("[TB] FAIL %s", name);
  endtask

  // Scoreboard: each retired result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (vo0 && ri0) begin
        if (q0.size() == 0) failNow("dut0 unexpected valid_o");
        else begin
          e0 = q0.pop_front();
          checkOutput("dut0 result", r0, e0.expd);
          checkOutput("dut0 valid cycle", 32'(cyc), 32'(e0.due));
        end
      end
      if (vo1 && ri1) begin
        if (q1.size() == 0) failNow("dut1 unexpected valid_o");
        else begin
          e1 = q1.pop_front();
          checkOutput("dut1 result", r1, e1.expd);
          checkOutput("dut1 valid cycle", 32'(cyc), 32'(e1.due));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] vop, input logic [31:0] va,
                               input logic [31:0] vb, input logic [31:0] vexp,
                               input int lat0, input int lat1, input bit push,
                               output int c);
    int w = 0;
    @(negedge clk);
    while (!(rdy0 && rdy1) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) failNow("ready_o timeout before request");
    valid_i = 1'b1;
    op      = vop;
    a       = va;
    b       = vb;
    c       = cyc;
    if (push) begin
      q0.push_back('{vexp, c + lat0});
      q1.push_back('{vexp, c + lat1});
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic drainQueues();
    int w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      failNow("result timeout");
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " dut0 valid_o"}, {31'b0, vo0}, 32'd0);
    checkOutput({tag, " dut0 result_o"}, r0, 32'd0);
    checkOutput({tag, " dut0 busy_o"}, {31'b0, bz0}, 32'd0);
    checkOutput({tag, " dut0 ready_o"}, {31'b0, rdy0}, 32'd0);
    checkOutput({tag, " dut1 valid_o"}, {31'b0, vo1}, 32'd0);
    checkOutput({tag, " dut1 result_o"}, r1, 32'd0);
    checkOutput({tag, " dut1 busy_o"}, {31'b0, bz1}, 32'd0);
    checkOutput({tag, " dut1 ready_o"}, {31'b0, rdy1}, 32'd0);
  endtask

  initial begin
    int c;
    int w;
    bit seen;

    rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; op = '0; a = '0; b = '0;
    ri0 = 1'b1; ri1 = 1'b1;

    vecs[0]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33};
    vecs[1]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33};
    vecs[2]  = '{DIVU,   32'd100,      32'd7,        32'd14,       33, 33};
    vecs[3]  = '{REMU,   32'd100,      32'd7,        32'd2,        33, 33};
    vecs[4]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000,  1, 33};
    vecs[5]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,  1, 33};
    vecs[6]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  1, 33};
    vecs[7]  = '{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  1, 33};
    vecs[8]  = '{DIVU,   32'd100,      32'd0,        32'hFFFFFFFF,  1,  1};
    vecs[9]  = '{REMU,   32'd100,      32'd0,        32'd100,       1,  1};
    vecs[10] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1,  1};
    vecs[11] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000,  1,  1};
    vecs[12] = '{DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF,  1,  1};
    vecs[13] = '{REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB,  1,  1};
    vecs[14] = '{DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33, 33};
    vecs[15] = '{REM,    32'd20,       32'hFFFFFFFD, 32'd2,        33, 33};
    vecs[16] = '{MUL,    32'h12345678, 32'd9,        32'hA3D70A38,  1, 33};
    vecs[17] = '{MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF,  1, 33};
    vecs[18] = '{MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000,  1, 33};
    vecs[19] = '{MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,  1, 33};
    vecs[20] = '{DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 33};
    vecs[21] = '{DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 33};
    vecs[22] = '{REM,    32'h80000000, 32'd1,        32'h00000000, 33, 33};
    vecs[23] = '{MULHU,  32'h80000000, 32'd3,        32'h00000001,  1, 33};
    vecs[24] = '{DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        33, 33};
    vecs[25] = '{REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33, 33};

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset dut0 ready_o", {31'b0, rdy0}, 32'd1);
    checkOutput("post-reset dut1 ready_o", {31'b0, rdy1}, 32'd1);

    mon_en = 1'b1;
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expd,
                    vecs[i].lat0, vecs[i].lat1, 1'b1, c);
      drainQueues();
    end

    $display("[TB] backpressure sequence");
    mon_en = 1'b0;
    ri0 = 1'b0; ri1 = 1'b0;
    applyStimulus(DIVU, 32'd100, 32'd7, 32'd14, 33, 33, 1'b0, c);
    w = 0;
    while (!vo0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("bp valid cycle", 32'(cyc), 32'(c + 33));
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp dut0 result hold", r0, 32'd14);
      checkOutput("bp dut1 result hold", r1, 32'd14);
      checkOutput("bp dut0 valid hold", {31'b0, vo0}, 32'd1);
      checkOutput("bp dut0 ready_o low", {31'b0, rdy0}, 32'd0);
      checkOutput("bp dut1 ready_o low", {31'b0, rdy1}, 32'd0);
      @(negedge clk);
    end
    ri0 = 1'b1; ri1 = 1'b1;
    @(negedge clk);
    checkOutput("bp release dut0 ready_o", {31'b0, rdy0}, 32'd1);
    checkOutput("bp release dut1 ready_o", {31'b0, rdy1}, 32'd1);
    checkOutput("bp release dut0 valid_o", {31'b0, vo0}, 32'd0);

    $display("[TB] kill sequence");
    seen = 1'b0;
    applyStimulus(DIV, 32'hFFFFFF9C, 32'd7, 32'd0, 33, 33, 1'b0, c);
    while (cyc < c + 15) begin
      if (vo0 || vo1) seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("kill dut0 busy before kill", {31'b0, bz0}, 32'd1);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    if (vo0 || vo1) seen = 1'b1;
    checkOutput("kill no valid_o seen", {31'b0, seen}, 32'd0);
    checkOutput("kill dut0 busy_o", {31'b0, bz0}, 32'd0);
    checkOutput("kill dut0 ready_o", {31'b0, rdy0}, 32'd1);
    checkOutput("kill dut1 busy_o", {31'b0, bz1}, 32'd0);
    mon_en = 1'b1;
    applyStimulus(DIVU, 32'd9, 32'd3, 32'd3, 33, 33, 1'b1, c);
    drainQueues();

    $display("[TB] reset sequence");
    mon_en = 1'b0;
    applyStimulus(DIV, 32'd1000, 32'd3, 32'd0, 33, 33, 1'b0, c);
    while (cyc < c + 5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetOutputs("mid-op reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset release dut0 ready_o", {31'b0, rdy0}, 32'd1);
    checkOutput("reset release dut1 ready_o", {31'b0, rdy1}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      if (vo0 || vo1) seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("reset no partial result", {31'b0, seen}, 32'd0);

    mon_en = 1'b1;
    applyStimulus(REMU, 32'd100, 32'd7, 32'd2, 33, 33, 1'b1, c);
    drainQueues();
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
